// File: rtl/addr_table_ctrl_if.sv
// Bundle between the ingress parsers / address table and addr_table_ctrl.
//   master : the controller side (accepts requests, issues table commands,
//            returns forwarding results)
//   slave  : the environment side (ingress parsers + address table)
// Signals:
//   req_valid/req_ready      per-port request handshake (ready is a one-hot pulse)
//   req_src_mac/req_dst_mac  flattened, port p at [p*MAC_W +: MAC_W]
//   rsp_valid/hit/port/drop  one-hot forwarding result back to the ingress port
//   tbl_valid/write/mac/port table command (lookup or learn)
//   tbl_rsp_valid/hit/port   lookup result from the table
interface addr_table_ctrl_if #(
    parameter int NUM_PORTS = 4,
    parameter int MAC_W     = 48,
    parameter int PORT_W    = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0]       req_valid;
    logic [NUM_PORTS-1:0]       req_ready;
    logic [NUM_PORTS*MAC_W-1:0] req_src_mac;
    logic [NUM_PORTS*MAC_W-1:0] req_dst_mac;
    logic [NUM_PORTS-1:0]       rsp_valid;
    logic                       rsp_hit;
    logic [PORT_W-1:0]          rsp_port;
    logic                       rsp_drop;
    logic                       tbl_valid;
    logic                       tbl_write;
    logic [MAC_W-1:0]           tbl_mac;
    logic [PORT_W-1:0]          tbl_port;
    logic                       tbl_rsp_valid;
    logic                       tbl_hit;
    logic [PORT_W-1:0]          tbl_rsp_port;

    modport master (
        input  req_valid, req_src_mac, req_dst_mac,
        input  tbl_rsp_valid, tbl_hit, tbl_rsp_port,
        output req_ready, rsp_valid, rsp_hit, rsp_port, rsp_drop,
        output tbl_valid, tbl_write, tbl_mac, tbl_port
    );

    modport slave (
        output req_valid, req_src_mac, req_dst_mac,
        output tbl_rsp_valid, tbl_hit, tbl_rsp_port,
        input  req_ready, rsp_valid, rsp_hit, rsp_port, rsp_drop,
        input  tbl_valid, tbl_write, tbl_mac, tbl_port
    );
endinterface

// File: rtl/addr_table_ctrl.sv
// addr_table_ctrl: shares one single-ported MAC learning table between
// NUM_PORTS ingress ports. Requests are granted round-robin; each granted
// request runs dst lookup -> src learn -> forwarding response, one at a time.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset (aborts any request in flight)
//   bus  addr_table_ctrl_if.master (request, response and table signals)
module addr_table_ctrl #(
    parameter int NUM_PORTS = 4,
    parameter int MAC_W     = 48,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic              clk,
    input  logic              rst,
    addr_table_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_LK, LEARN, RESP} state_t;

    // bit 40 is the I/G bit of the first transmitted octet
    localparam int MCAST_BIT = MAC_W - 8;

    state_t            state, state_nxt;
    logic [PORT_W-1:0] rr_ptr;
    logic [PORT_W-1:0] gnt_q;
    logic [MAC_W-1:0]  src_q, dst_q;
    logic              hit_q;
    logic [PORT_W-1:0] hit_port_q;

    logic              gnt_found;
    logic [PORT_W-1:0] gnt_idx;
    logic [MAC_W-1:0]  gnt_src, gnt_dst;
    logic              dst_bcast;

    // Round-robin search starting at rr_ptr.
    always_comb begin : rr_arb
        int p;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        p         = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            p = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!gnt_found && bus.req_valid[p]) begin
                gnt_found = 1'b1;
                gnt_idx   = PORT_W'(p);
            end
        end
    end

    assign gnt_src   = bus.req_src_mac[gnt_idx*MAC_W +: MAC_W];
    assign gnt_dst   = bus.req_dst_mac[gnt_idx*MAC_W +: MAC_W];
    assign dst_bcast = &gnt_dst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            hit_q      <= 1'b0;
            hit_port_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && gnt_found) begin
                gnt_q      <= gnt_idx;
                src_q      <= gnt_src;
                dst_q      <= gnt_dst;
                rr_ptr     <= PORT_W'((int'(gnt_idx) + 1) % NUM_PORTS);
                // broadcast skips the lookup, so the result is a flood
                hit_q      <= 1'b0;
                hit_port_q <= '0;
            end
            // results outside WAIT_LK (e.g. late ones after an abort) are dropped
            if (state == WAIT_LK && bus.tbl_rsp_valid) begin
                hit_q      <= bus.tbl_hit;
                hit_port_q <= bus.tbl_rsp_port;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_hit   = 1'b0;
        bus.rsp_port  = '0;
        bus.rsp_drop  = 1'b0;
        bus.tbl_valid = 1'b0;
        bus.tbl_write = 1'b0;
        bus.tbl_mac   = '0;
        bus.tbl_port  = '0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    // keep the accept pulse quiet while reset is held
                    if (!rst) bus.req_ready = NUM_PORTS'(1) << gnt_idx;
                    state_nxt = dst_bcast ? LEARN : LOOKUP;
                end
            end
            LOOKUP: begin
                bus.tbl_valid = 1'b1;
                bus.tbl_mac   = dst_q;
                state_nxt     = WAIT_LK;
            end
            WAIT_LK: begin
                if (bus.tbl_rsp_valid) state_nxt = LEARN;
            end
            LEARN: begin
                // multicast sources are never learned
                if (!src_q[MCAST_BIT]) begin
                    bus.tbl_valid = 1'b1;
                    bus.tbl_write = 1'b1;
                    bus.tbl_mac   = src_q;
                    bus.tbl_port  = gnt_q;
                end
                state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = NUM_PORTS'(1) << gnt_q;
                bus.rsp_hit   = hit_q;
                bus.rsp_port  = hit_port_q;
                bus.rsp_drop  = hit_q && (hit_port_q == gnt_q);
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_addr_table_ctrl.sv
// Bench for addr_table_ctrl: emulates the address table (associative array,
// programmable lookup latency), logs DUT events at negedge, runs directed
// vectors, multi-cycle corner sequences and a randomized phase against a
// reference model.
module tb_addr_table_ctrl;
    localparam int NP = 4;
    localparam int MW = 48;

    typedef struct {
        logic [3:0]  vm;
        logic [47:0] src;
        logic [47:0] dst;
        int          lat;
        int          gnt;
        int          nlk;
        int          nln;
        logic        hit;
        logic [1:0]  port;
        logic        drop;
        int          dly;
    } vec_t;

    typedef struct {
        int          ngnt, nrsp, gnt, nlk, nln, dly;
        logic [47:0] lkmac, lnmac;
        logic [1:0]  lnport, port;
        logic [3:0]  vec;
        logic        hit, drop;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    addr_table_ctrl_if #(.NUM_PORTS(NP), .MAC_W(MW)) bus();
    addr_table_ctrl #(.NUM_PORTS(NP), .MAC_W(MW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    // event log written by the monitor
    int          cyc = 0, g_cnt = 0, lk_cnt = 0, ln_cnt = 0, r_cnt = 0;
    int          g_cyc = 0, r_cyc = 0, g_idx = 0;
    logic [47:0] lk_mac = '0, ln_mac = '0;
    logic [1:0]  ln_port = '0, r_port = '0;
    logic [3:0]  r_vec = '0;
    logic        r_hit = 1'b0, r_drop = 1'b0;
    int          gq[$];
    logic [3:0]  rq[$];

    // table emulation state
    logic [1:0]  mem [logic [47:0]];
    int          lat = 1;
    int          pend = 0;
    logic        p_hit = 1'b0;
    logic [1:0]  p_port = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {bus.req_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_port, bus.rsp_drop,
                bus.tbl_valid, bus.tbl_write, bus.tbl_mac, bus.tbl_port};
    endfunction

    function automatic logic [47:0] mk(input logic [7:0] lsb);
        return {8'h02, 32'h0, lsb};
    endfunction

    // Monitor + table responder, all at negedge.
    initial begin
        bus.tbl_rsp_valid = 1'b0;
        bus.tbl_hit       = 1'b0;
        bus.tbl_rsp_port  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.tbl_rsp_valid = 1'b0;
            bus.tbl_hit       = 1'b0;
            bus.tbl_rsp_port  = '0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.tbl_rsp_valid = 1'b1;
                    bus.tbl_hit       = p_hit;
                    // port is meaningless on a miss; make it noise
                    bus.tbl_rsp_port  = p_hit ? p_port : 2'($urandom_range(0, 3));
                end
            end
            if (!rst) begin
                check("req_ready_onehot", 64'($onehot0(bus.req_ready)), 64'(1));
                if (bus.req_ready != 0) begin
                    g_cnt++;
                    g_cyc = cyc;
                    for (int p = 0; p < NP; p++) if (bus.req_ready[p]) g_idx = p;
                    gq.push_back(g_idx);
                end
                if (bus.tbl_valid && !bus.tbl_write) begin
                    lk_cnt++;
                    lk_mac = bus.tbl_mac;
                    pend   = lat;
                    p_hit  = (mem.exists(bus.tbl_mac) != 0);
                    p_port = p_hit ? mem[bus.tbl_mac] : 2'd0;
                end
                if (bus.tbl_valid && bus.tbl_write) begin
                    ln_cnt++;
                    ln_mac  = bus.tbl_mac;
                    ln_port = bus.tbl_port;
                    mem[bus.tbl_mac] = bus.tbl_port;
                end
                if (!bus.tbl_valid)
                    check("tbl_idle_zero", 64'({bus.tbl_write, bus.tbl_mac, bus.tbl_port}), 64'(0));
                if (bus.rsp_valid != 0) begin
                    r_cnt++;
                    r_cyc  = cyc;
                    r_vec  = bus.rsp_valid;
                    r_hit  = bus.rsp_hit;
                    r_port = bus.rsp_port;
                    r_drop = bus.rsp_drop;
                    rq.push_back(bus.rsp_valid);
                end else begin
                    check("rsp_idle_zero", 64'({bus.rsp_hit, bus.rsp_port, bus.rsp_drop}), 64'(0));
                end
            end
        end
    end

    // One request from issue to response; req_valid dropped once the response is seen.
    task automatic run_req(input logic [3:0] vm, input logic [191:0] s, input logic [191:0] d,
                           input int lt, output obs_t o);
        int g0, l0, n0, r0, n;
        lat = lt;
        @(posedge clk); #1;
        g0 = g_cnt; l0 = lk_cnt; n0 = ln_cnt; r0 = r_cnt;
        bus.req_src_mac = s;
        bus.req_dst_mac = d;
        bus.req_valid   = vm;
        n = 0;
        while (r_cnt == r0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        bus.req_valid = '0;
        o.ngnt = g_cnt - g0;  o.nrsp = r_cnt - r0;
        o.nlk  = lk_cnt - l0; o.nln  = ln_cnt - n0;
        o.gnt  = g_idx;       o.dly  = r_cyc - g_cyc;
        o.lkmac = lk_mac;     o.lnmac = ln_mac;  o.lnport = ln_port;
        o.vec  = r_vec;       o.hit  = r_hit;    o.port = r_port;  o.drop = r_drop;
    endtask

    task automatic cmp(input string t, input obs_t o, input int gnt, input int nlk, input int nln,
                       input int dly, input logic hit, input logic [1:0] port, input logic drop,
                       input logic [47:0] src, input logic [47:0] dst);
        check({t, "_ngrant"}, 64'(o.ngnt), 64'(1));
        check({t, "_nrsp"}, 64'(o.nrsp), 64'(1));
        check({t, "_grant"}, 64'(o.gnt), 64'(gnt));
        check({t, "_rsp_valid"}, 64'(o.vec), 64'(4'(1) << gnt));
        check({t, "_nlookup"}, 64'(o.nlk), 64'(nlk));
        if (nlk > 0) check({t, "_lookup_mac"}, 64'(o.lkmac), 64'(dst));
        check({t, "_nlearn"}, 64'(o.nln), 64'(nln));
        if (nln > 0) begin
            check({t, "_learn_mac"}, 64'(o.lnmac), 64'(src));
            check({t, "_learn_port"}, 64'(o.lnport), 64'(gnt));
        end
        check({t, "_hit"}, 64'(o.hit), 64'(hit));
        if (hit) check({t, "_port"}, 64'(o.port), 64'(port));
        check({t, "_drop"}, 64'(o.drop), 64'(drop));
        check({t, "_delay"}, 64'(o.dly), 64'(dly));
    endtask

    initial begin
        vec_t        vt[8];
        obs_t        o;
        logic [47:0] bc;
        logic [47:0] mc;
        logic [47:0] src_pool[8];
        logic [1:0]  ref_tbl [logic [47:0]];
        logic [191:0] s, d;
        logic [47:0] es, ed;
        logic [3:0]  vm;
        logic        ehit, edrop;
        logic [1:0]  eport;
        int          g0, r0, l0, n, rr, g, lt;
        int          exp_seq[5];

        bc = '1;
        mc = 48'h01_00_5E_00_00_01;
        //          vm       src       dst        lat gnt nlk nln hit  port  drop dly
        vt[0] = '{4'b0010, mk(8'h01), mk(8'hAA), 1, 1, 1, 1, 1'b0, 2'd0, 1'b0, 4};
        vt[1] = '{4'b0100, mk(8'h22), mk(8'hB2), 1, 2, 1, 1, 1'b1, 2'd2, 1'b1, 4};
        vt[2] = '{4'b0100, mk(8'h22), mk(8'hB3), 1, 2, 1, 1, 1'b1, 2'd3, 1'b0, 4};
        vt[3] = '{4'b0001, mk(8'h10), bc,        1, 0, 0, 1, 1'b0, 2'd0, 1'b0, 2};
        vt[4] = '{4'b1000, mc,        mk(8'h01), 2, 3, 1, 0, 1'b1, 2'd1, 1'b0, 5};
        vt[5] = '{4'b1010, mk(8'h33), mk(8'h10), 3, 1, 1, 1, 1'b1, 2'd0, 1'b0, 6};
        vt[6] = '{4'b1010, mk(8'h44), mk(8'h33), 1, 3, 1, 1, 1'b1, 2'd1, 1'b0, 4};
        vt[7] = '{4'b0010, mk(8'h55), mk(8'h33), 1, 1, 1, 1, 1'b1, 2'd1, 1'b1, 4};

        bus.req_valid   = '0;
        bus.req_src_mac = '0;
        bus.req_dst_mac = '0;

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs(), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // pre-seeded entries to produce hits on known ports
        mem[mk(8'hB2)] = 2'd2;
        mem[mk(8'hB3)] = 2'd3;

        for (int i = 0; i < 8; i++) begin
            run_req(vt[i].vm, {4{vt[i].src}}, {4{vt[i].dst}}, vt[i].lat, o);
            cmp($sformatf("vec%0d", i), o, vt[i].gnt, vt[i].nlk, vt[i].nln, vt[i].dly,
                vt[i].hit, vt[i].port, vt[i].drop, vt[i].src, vt[i].dst);
        end

        // reset while waiting for a slow lookup; its result lands after release
        lat = 4;
        l0  = lk_cnt;
        @(posedge clk); #1;
        bus.req_src_mac = {4{mk(8'h77)}};
        bus.req_dst_mac = {4{mk(8'hAA)}};
        bus.req_valid   = 4'b0100;
        n = 0;
        while (lk_cnt == l0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_lookup_seen", 64'(lk_cnt - l0), 64'(1));
        bus.req_valid = '0;
        g0  = g_cnt;
        r0  = r_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", outs(), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_rsp", 64'(r_cnt - r0), 64'(0));
        check("abort_no_grant", 64'(g_cnt - g0), 64'(0));

        // all ports held: rotation restarts at port 0
        lat = 1;
        gq.delete();
        rq.delete();
        r0 = r_cnt;
        bus.req_src_mac = {4{mk(8'h66)}};
        bus.req_dst_mac = {4{mk(8'hAA)}};
        bus.req_valid   = 4'b1111;
        n = 0;
        while (r_cnt - r0 < 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        bus.req_valid = '0;
        check("held_ngrant", 64'(gq.size()), 64'(5));
        check("held_nrsp", 64'(rq.size()), 64'(5));
        exp_seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) check($sformatf("held_grant%0d", i), 64'(gq[i]), 64'(exp_seq[i]));
            if (i < rq.size()) check($sformatf("held_rsp%0d", i), 64'(rq[i]), 64'(4'(1) << exp_seq[i]));
        end

        // randomized phase from a clean reset and empty table
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mem.delete();
        for (int i = 0; i < 8; i++)
            src_pool[i] = (i < 6) ? mk(8'(i)) : {8'h01, 8'h00, 8'h5E, 16'h0, 8'(i)};
        rr = 0;
        for (int t = 0; t < 150; t++) begin
            vm = 4'($urandom_range(1, 15));
            for (int p = 0; p < NP; p++) begin
                int r;
                s[p*48 +: 48] = src_pool[$urandom_range(0, 7)];
                r = $urandom_range(0, 6);
                d[p*48 +: 48] = (r == 0) ? bc : mk(8'(r - 1));
            end
            lt = $urandom_range(1, 3);
            g  = -1;
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (rr + k) % NP;
                if (g < 0 && vm[p]) g = p;
            end
            es    = s[g*48 +: 48];
            ed    = d[g*48 +: 48];
            ehit  = (ed != bc) && (ref_tbl.exists(ed) != 0);
            eport = ehit ? ref_tbl[ed] : 2'd0;
            edrop = ehit && (int'(eport) == g);
            run_req(vm, s, d, lt, o);
            cmp($sformatf("rnd%0d", t), o, g, (ed == bc) ? 0 : 1, es[40] ? 0 : 1,
                (ed == bc) ? 2 : 3 + lt, ehit, eport, edrop, es, ed);
            if (!es[40]) ref_tbl[es] = 2'(g);
            rr = (g + 1) % NP;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
